boot_ctrl: RTL and testbench
============================

# boot_ctrl

Boot and run sequencer for the comproc CPU. It takes a program as a byte stream from the host link and writes it into instruction memory. It then zeroes the 256-byte data memory and runs the CPU until the CPU writes its result address or a timeout expires. Finally it returns a two-byte report to the host. It sits between the host link, the instruction memory write port, the data memory port and the CPU's `rst`/memory signals.

## Interface
- `TIMEOUT`, 10000: CPU run cycles allowed before the run is aborted; must be at least 1.
- `RESULT_ADDR`, 8'h01: data address whose CPU write ends the run.
- `IMEM_DEPTH`, 1024: instruction memory words; word indices at or above this are discarded.

- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: host byte stream in.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: report byte stream out.
- `imem_we` out 1, `imem_addr` out 10, `imem_wdata` out 16: instruction memory write port.
- `cpu_rst` out 1: drives the CPU `rst`.
- `cpu_mem_addr` in 8, `cpu_mem_wr` in 1, `cpu_wr_data` in 8: CPU data-memory request.
- `dmem_addr` out 8, `dmem_wr` out 1, `dmem_wdata` out 8: data memory port.

## Operation
- A byte transfers on a posedge where both `valid` and `ready` are high.
- `rx_ready` is 1 exactly in LEN_HI, LEN_LO, W_HI and W_LO.
- States and transitions:
  - LEN_HI: takes the length high byte; goes to LEN_LO.
  - LEN_LO: takes the length low byte, forming a 16-bit N. Goes to W_HI, or to CLEAR if N=0.
  - W_HI: takes the instruction high byte; goes to W_LO.
  - W_LO: takes the low byte. Word i (0-based) is written as `{hi,lo}` at `imem_addr`=i, only if i < IMEM_DEPTH. Words with i ≥ IMEM_DEPTH are consumed but not written. After word N-1 goes to CLEAR, otherwise to W_HI.
  - CLEAR: 256 cycles. `dmem_addr` runs 0..255 with `dmem_wr`=1 and `dmem_wdata`=0; goes to RUN.
  - RUN: `cpu_rst`=0. `dmem_addr`/`dmem_wr`/`dmem_wdata` follow the `cpu_*` inputs combinationally. A cycle counter starts at 0 on entry.
    - If `cpu_mem_wr` && `cpu_mem_addr`==RESULT_ADDR: capture `cpu_wr_data`, status=8'h00, go to REPORT. The write is still passed to dmem.
    - Otherwise, when the counter reaches TIMEOUT-1: status=8'h01, value=8'h00, go to REPORT.
    - A result write in the timeout cycle wins; status is 00.
  - REPORT: `tx_valid`=1.
    - `tx_data`=status until accepted, then `tx_data`=value.
    - After the second handshake, goes to LEN_HI.
    - `tx_data` must not change while `tx_valid` is high and the byte is not yet accepted.
- `cpu_rst`=1 in every state except RUN.
- Outside RUN and CLEAR: `dmem_wr`=0 and `dmem_addr`=0.
- `rst` in any state aborts the operation and returns to LEN_HI. Memory contents already written are left as they are.

## Timing
- Reset values:
  - state LEN_HI, `rx_ready`=1, `cpu_rst`=1.
  - `tx_valid`=0, `tx_data`=0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `dmem_wr`=0, `dmem_addr`=0, `dmem_wdata`=0.
- `imem_*` are registered. `imem_we` pulses for exactly one cycle, the cycle after the W_LO handshake.
- The cycle after the last W_LO handshake (or the LEN_LO handshake when N=0) is CLEAR cycle 0.
- RUN begins 256 cycles after CLEAR cycle 0. `cpu_rst` falls in that cycle.
- The result write is detected in the same cycle it is presented. `cpu_rst` rises and `tx_valid` rises on the next cycle.
- A timeout puts the design in REPORT exactly TIMEOUT cycles after RUN entry.
- Back-to-back rx bytes (`rx_valid` held high) are accepted one per cycle. There are no bubbles during loading.

## Test plan
- Load: N=2, words 0x1234 and 0xABCD, `rx_valid` always high. Required: `imem_we` pulses with (0,0x1234) then (1,0xABCD). CLEAR writes 0 to all 256 addresses. `cpu_rst` falls 257 cycles after the last byte.
- Result: in RUN, drive `cpu_mem_wr`=1, `cpu_mem_addr`=0x01, `cpu_wr_data`=0x2A. Required: with `tx_ready`=1, tx bytes are 0x00 then 0x2A, `cpu_rst`=1 next cycle, and state returns to LEN_HI.
- Timeout: TIMEOUT=20, no result write. Required: `cpu_rst` is 0 for exactly 20 cycles, then tx bytes 0x01, 0x00. Also drive the result write on cycle 19: status 0x00.
- Backpressure: hold `tx_ready`=0 for 5 cycles in REPORT. Required: `tx_valid`=1 and `tx_data` stable at status throughout, then the value byte follows after acceptance.
- Edge cases:
  - N=0: required to go straight to CLEAR with no `imem_we`.
  - N=1026: required to write words 0..1023 only, and consume words 1024 and 1025 without `imem_we`.
- Reset mid-operation: `rst` asserted mid-CLEAR (address 100) and mid-RUN. Required: next cycle `cpu_rst`=1, `dmem_wr`=0, `rx_ready`=1, `tx_valid`=0.

Source files
------------

// File: rtl/boot_ctrl.sv
// Boot and run sequencer: loads a program from the host link into instruction memory,
// clears data memory, runs the CPU until it writes the result address or times out, then reports.
module boot_ctrl #(
    parameter int         TIMEOUT     = 10000,
    parameter logic [7:0] RESULT_ADDR = 8'h01,
    parameter int         IMEM_DEPTH  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_rst,
    input  logic [7:0]  cpu_mem_addr,
    input  logic        cpu_mem_wr,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  dmem_addr,
    output logic        dmem_wr,
    output logic [7:0]  dmem_wdata
);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, W_HI, W_LO, CLEAR, RUN, REPORT} state_t;

    localparam logic [16:0] DEPTH    = 17'(IMEM_DEPTH);
    localparam logic [31:0] RUN_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] len;
    logic [15:0] widx;
    logic [7:0]  hi_byte;
    logic [7:0]  clr_addr;
    logic [31:0] run_cnt;
    logic [7:0]  status;
    logic [7:0]  value;
    logic        tx_phase;
    logic        rx_fire;
    logic        tx_fire;
    logic        result_hit;

    assign rx_ready   = (state == LEN_HI) || (state == LEN_LO) || (state == W_HI) || (state == W_LO);
    assign cpu_rst    = (state != RUN);
    assign tx_valid   = (state == REPORT);
    // tx_phase only advances on a handshake, so the offered byte is stable under backpressure
    assign tx_data    = tx_valid ? (tx_phase ? value : status) : 8'h00;
    assign rx_fire    = rx_valid && rx_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign result_hit = cpu_mem_wr && (cpu_mem_addr == RESULT_ADDR);

    always_comb begin
        dmem_addr  = 8'h00;
        dmem_wr    = 1'b0;
        dmem_wdata = 8'h00;
        if (state == CLEAR) begin
            dmem_addr = clr_addr;
            dmem_wr   = 1'b1;
        end else if (state == RUN) begin
            dmem_addr  = cpu_mem_addr;
            dmem_wr    = cpu_mem_wr;
            dmem_wdata = cpu_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LEN_HI;
            len        <= 16'h0000;
            widx       <= 16'h0000;
            hi_byte    <= 8'h00;
            clr_addr   <= 8'h00;
            run_cnt    <= 32'h0;
            status     <= 8'h00;
            value      <= 8'h00;
            tx_phase   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 10'h000;
            imem_wdata <= 16'h0000;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN_HI: if (rx_fire) begin
                    len[15:8] <= rx_data;
                    state     <= LEN_LO;
                end
                LEN_LO: if (rx_fire) begin
                    len[7:0] <= rx_data;
                    widx     <= 16'h0000;
                    clr_addr <= 8'h00;
                    state    <= ({len[15:8], rx_data} == 16'h0000) ? CLEAR : W_HI;
                end
                W_HI: if (rx_fire) begin
                    hi_byte <= rx_data;
                    state   <= W_LO;
                end
                W_LO: if (rx_fire) begin
                    // words beyond the memory are still consumed so the stream stays aligned
                    if ({1'b0, widx} < DEPTH) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= widx[9:0];
                        imem_wdata <= {hi_byte, rx_data};
                    end
                    widx  <= widx + 16'd1;
                    state <= (widx == len - 16'd1) ? CLEAR : W_HI;
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 8'd1;
                    if (clr_addr == 8'hFF) begin
                        run_cnt <= 32'h0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    // a result write in the final cycle takes priority over the timeout
                    if (result_hit) begin
                        value    <= cpu_wr_data;
                        status   <= 8'h00;
                        tx_phase <= 1'b0;
                        state    <= REPORT;
                    end else if (run_cnt == RUN_LAST) begin
                        value    <= 8'h00;
                        status   <= 8'h01;
                        tx_phase <= 1'b0;
                        state    <= REPORT;
                    end
                end
                REPORT: if (tx_fire) begin
                    if (!tx_phase) begin
                        tx_phase <= 1'b1;
                    end else begin
                        tx_phase <= 1'b0;
                        state    <= LEN_HI;
                    end
                end
                default: state <= LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: randomized program loads and CPU runs checked against
// a transaction-level model of load, clear, run and report behaviour.
module tb_boot_ctrl;

    localparam int         TIMEOUT = 20;
    localparam logic [7:0] RA      = 8'h01;
    localparam int         DEPTH   = 1024;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic [7:0]  cpu_mem_addr;
    logic        cpu_mem_wr;
    logic [7:0]  cpu_wr_data;
    logic [7:0]  dmem_addr;
    logic        dmem_wr;
    logic [7:0]  dmem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [25:0] imem_q[$];
    logic [15:0] clr_q[$];

    boot_ctrl #(.TIMEOUT(TIMEOUT), .RESULT_ADDR(RA), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wr(cpu_mem_wr), .cpu_wr_data(cpu_wr_data),
        .dmem_addr(dmem_addr), .dmem_wr(dmem_wr), .dmem_wdata(dmem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every instruction write and every data write made while the CPU is held in reset
    always @(negedge clk) begin
        if (imem_we === 1'b1) imem_q.push_back({imem_addr, imem_wdata});
        if (cpu_rst === 1'b1 && dmem_wr === 1'b1) clr_q.push_back({dmem_addr, dmem_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_mem_wr = 1'b0;
        chk_eq("abort_cpu_rst", cpu_rst, 1);
        chk_eq("abort_dmem_wr", dmem_wr, 0);
        chk_eq("abort_rx_ready", rx_ready, 1);
        chk_eq("abort_tx_valid", tx_valid, 0);
    endtask

    // res_cyc: run cycle of the result write (outside 0..TIMEOUT-1 means none)
    // abort_mode: 0 none, 1 reset at clear address 100, 2 reset on run cycle 5
    task automatic run_boot(input int n, input bit fixed, input int res_cyc,
                            input logic [7:0] rval, input int bp, input int abort_mode);
        logic [15:0] words[$];
        logic [7:0]  bytes[$];
        logic [15:0] nn;
        int stall, t, c, bad, exp_len, exp_w, lim;
        logic [7:0] exp_status, exp_value;

        nn = 16'(n);
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
        if (fixed && n == 2) begin
            words[0] = 16'h1234;
            words[1] = 16'hABCD;
        end
        bytes.push_back(nn[15:8]);
        bytes.push_back(nn[7:0]);
        foreach (words[i]) begin
            bytes.push_back(words[i][15:8]);
            bytes.push_back(words[i][7:0]);
        end

        imem_q.delete();
        clr_q.delete();

        stall = 0;
        foreach (bytes[i]) begin
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            if (rx_ready !== 1'b1) stall++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        chk_eq("rx_stall", stall, 0);

        t = 1;
        while (cpu_rst === 1'b1 && t < 600) begin
            if (abort_mode == 1 && dmem_wr === 1'b1 && dmem_addr == 8'd100) begin
                do_reset();
                return;
            end
            @(negedge clk);
            t++;
        end
        chk_eq("run_latency", t, 257);

        exp_w = (n < DEPTH) ? n : DEPTH;
        chk_eq("imem_count", imem_q.size(), exp_w);
        lim = (imem_q.size() < exp_w) ? imem_q.size() : exp_w;
        bad = 0;
        for (int i = 0; i < lim; i++)
            if (imem_q[i] !== {10'(i), words[i]}) bad++;
        chk_eq("imem_words", bad, 0);

        chk_eq("clr_count", clr_q.size(), 256);
        bad = 0;
        foreach (clr_q[i])
            if (clr_q[i] !== (16'(i) << 8)) bad++;
        chk_eq("clr_seq", bad, 0);

        if (res_cyc >= 0 && res_cyc < TIMEOUT) begin
            exp_len    = res_cyc + 1;
            exp_status = 8'h00;
            exp_value  = rval;
        end else begin
            exp_len    = TIMEOUT;
            exp_status = 8'h01;
            exp_value  = 8'h00;
        end

        c = 0;
        bad = 0;
        while (cpu_rst === 1'b0 && c < TIMEOUT + 10) begin
            if (abort_mode == 2 && c == 5) begin
                do_reset();
                return;
            end
            if (c == res_cyc) begin
                cpu_mem_wr   = 1'b1;
                cpu_mem_addr = RA;
                cpu_wr_data  = rval;
            end else begin
                cpu_mem_addr = 8'($urandom);
                cpu_mem_wr   = 1'($urandom);
                cpu_wr_data  = 8'($urandom);
                if (cpu_mem_addr == RA) cpu_mem_wr = 1'b0;
            end
            #1;
            if (dmem_addr !== cpu_mem_addr || dmem_wr !== cpu_mem_wr || dmem_wdata !== cpu_wr_data) bad++;
            @(negedge clk);
            c++;
        end
        cpu_mem_wr   = 1'b0;
        cpu_mem_addr = 8'h00;
        cpu_wr_data  = 8'h00;
        chk_eq("run_len", c, exp_len);
        chk_eq("dmem_pass", bad, 0);

        chk_eq("tx_valid_1", tx_valid, 1);
        chk_eq("tx_status", tx_data, exp_status);
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            tx_ready = 1'b0;
            if (tx_valid !== 1'b1 || tx_data !== exp_status) bad++;
            @(negedge clk);
        end
        chk_eq("tx_hold", bad, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk_eq("tx_valid_2", tx_valid, 1);
        chk_eq("tx_value", tx_data, exp_value);
        @(negedge clk);
        tx_ready = 1'b0;
        chk_eq("tx_done", tx_valid, 0);
        chk_eq("back_to_len", rx_ready, 1);
    endtask

    initial begin
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        tx_ready     = 1'b0;
        cpu_mem_addr = 8'h00;
        cpu_mem_wr   = 1'b0;
        cpu_wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_eq("rst_rx_ready", rx_ready, 1);
        chk_eq("rst_cpu_rst", cpu_rst, 1);
        chk_eq("rst_tx_valid", tx_valid, 0);
        chk_eq("rst_tx_data", tx_data, 0);
        chk_eq("rst_imem", {imem_we, imem_addr, imem_wdata}, 0);
        chk_eq("rst_dmem", {dmem_wr, dmem_addr, dmem_wdata}, 0);

        run_boot(2, 1'b1, 3, 8'h2A, 0, 0);
        run_boot(3, 1'b0, -1, 8'h00, 5, 0);
        run_boot(2, 1'b0, TIMEOUT - 1, 8'($urandom), 2, 0);
        run_boot(0, 1'b0, 7, 8'h5C, 1, 0);
        run_boot(1026, 1'b0, 4, 8'hE1, 0, 0);
        run_boot(4, 1'b0, 2, 8'h11, 0, 1);
        run_boot(1, 1'b0, 10, 8'h22, 0, 2);
        for (int k = 0; k < 4; k++)
            run_boot($urandom_range(1, 8), 1'b0, $urandom_range(0, 25), 8'($urandom),
                     $urandom_range(0, 3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
